imm_ext_pipe: RTL and testbench
===============================

Name: imm_ext_pipe

Overview:
Parametrised, pipelined immediate-extension unit. It is the successor to the fixed 16-to-30 combinational sign extender in the MIPS datapath. It supports sign, zero, upper-load (LUI) and branch-offset (sign-extend plus shift) modes, with a truncation flag for the branch mode. It uses a 2-stage valid/ready pipeline so it can sit between decode and execute in the pipelined core.

Parameters:
- IN_W, 16, immediate width. Legal range: IN_W >= 2.
- OUT_W, 30, result width. Legal range: OUT_W >= IN_W.
- SHIFT, 2, left shift applied in BRANCH mode. Legal range: 0 <= SHIFT < OUT_W.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input transaction present.
- in_ready  out  1  unit can accept this cycle.
- in_imm  in  IN_W  immediate field.
- in_mode  in  2  00 SIGN, 01 ZERO, 10 LUI, 11 BRANCH.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_data  out  OUT_W  extended result.
- out_trunc  out  1  BRANCH result lost significant bits.
- busy  out  1  either pipeline stage holds a valid entry.

Behaviour:
- **Reset (rst_n low, asynchronous):**
  - s1_valid=0, s2_valid=0.
  - out_valid=0, out_data=0, out_trunc=0, busy=0.
  - in_ready=0 while rst_n is low (gated with rst_n); in_ready=1 from the first cycle after release.
  - In-flight entries are discarded and never reappear.
- **Transfers:** input transfer when in_valid & in_ready at a rising edge; output transfer when out_valid & out_ready at a rising edge.
- **Stage 1:** registers in_imm and in_mode.
- **Stage 2:** registers the extended result and trunc flag computed from stage 1.
  - out_valid = s2_valid; out_data and out_trunc are driven directly from stage-2 registers.
- **Latency:** an entry accepted at edge N has out_valid high after edge N+1. Throughput is 1 per cycle while out_ready=1.
- **Flow control:**
  - s2 loads when s1_valid & (!s2_valid | out_ready).
  - s1 loads when in_valid & in_ready.
  - in_ready = rst_n & (!s1_valid | !s2_valid | out_ready). This is combinational back-propagation, with no skid buffer.
- **Stall:** while out_valid & !out_ready, out_data and out_trunc hold stable and s2 is not overwritten.
- **Full:** with both stages full and out_ready=0, in_ready=0 in that same cycle. No entry is dropped or duplicated, and order is strictly FIFO.
- **Simultaneous events:** output transfer and input transfer in the same edge when full are both performed; the pipeline advances by one.
- **Mode arithmetic** (x = in_imm):
  - SIGN: out = {(OUT_W-IN_W){x[IN_W-1]}, x}.
  - ZERO: out = {(OUT_W-IN_W){0}, x}.
  - LUI: out = {x, (OUT_W-IN_W){0}}. If IN_W==OUT_W, this is a passthrough.
  - BRANCH: compute t = sext(x) << SHIFT at width OUT_W+SHIFT; out = t[OUT_W-1:0].
  - trunc = 1 iff t[OUT_W+SHIFT-1:OUT_W-1] is not all equal. For all other modes trunc = 0.
- **IN_W==OUT_W:** SIGN and ZERO both equal x.
- **busy** = s1_valid | s2_valid.
- **Illegal parameters** fail elaboration; there is no runtime fallback.

Decomposition:
- Shared package imm_ext_pkg:
  - Mode constants: EXT_SIGN=2'b00, EXT_ZERO=2'b01, EXT_LUI=2'b10, EXT_BRANCH=2'b11.
  - Mode field width constant EXT_MODE_W=2.
- One combinational sub-module, imm_ext_core (IN_W, OUT_W, SHIFT): mode, imm -> data, trunc.
- Top level imm_ext_pipe holds the two pipeline stages and the handshake logic only.

Test Plan:
All scenarios use defaults IN_W=16, OUT_W=30, SHIFT=2 unless stated; out_ready=1 unless stated.
1. SIGN, in_imm=16'd23 -> out_data=30'd23, out_trunc=0, out_valid one edge after acceptance. Then in_imm=16'hFFE9 (-23) -> out_data=30'h3FFFFFE9.
2. ZERO, in_imm=16'hFFE9 -> 30'h0000FFE9. LUI, in_imm=16'h1234 -> 30'h048D0000.
3. BRANCH:
   - in_imm=16'hFFFF -> 30'h3FFFFFFC, trunc=0.
   - in_imm=16'h7FFF -> 30'h0001FFFC, trunc=0.
   - Separate instance with OUT_W=16, in_imm=16'h2000 -> out_data=16'h8000, trunc=1.
4. Backpressure: stream 4 mixed-mode entries back-to-back, with out_ready=0 for 3 cycles after the first result.
   - in_ready drops once both stages are full.
   - out_data holds stable during the stall.
   - All 4 results emerge in order with no drop or duplicate.
5. Simultaneous transfer with the pipeline full: raise out_ready and in_valid together -> one result out and one entry in on the same edge; busy stays 1.
6. Reset mid-flight:
   - With 2 entries in flight, assert rst_n=0 between edges -> out_valid=0, out_data=0, in_ready=0 immediately.
   - After release, in_ready=1 and only newly accepted entries ever appear at the output.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Package for the immediate-extension pipeline.
// Holds the extension-mode encoding used by the core, the pipeline and
// anything that drives them.
package imm_ext_pkg;

  localparam int EXT_MODE_W = 2;

  // 00 SIGN, 01 ZERO, 10 LUI (immediate into the top bits),
  // 11 BRANCH (sign-extend then shift left, with overflow flag)
  typedef enum logic [EXT_MODE_W-1:0] {
    EXT_SIGN   = 2'b00,
    EXT_ZERO   = 2'b01,
    EXT_LUI    = 2'b10,
    EXT_BRANCH = 2'b11
  } ext_mode_e;

  localparam int PIPE_STAGES = 2;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle for imm_ext_pipe.
//   in_valid/in_ready/in_imm/in_mode : request side (producer -> unit)
//   out_valid/out_ready/out_data/out_trunc : result side (unit -> consumer)
//   busy : unit holds at least one entry
// master = producer/consumer side, slave = the extension unit.
interface imm_ext_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 30
);
  import imm_ext_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W-1:0]       in_imm;
  logic [EXT_MODE_W-1:0] in_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      out_data;
  logic                  out_trunc;
  logic                  busy;

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_trunc, busy
  );

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_trunc, busy
  );

endinterface

// File: rtl/imm_ext_core.sv
// Combinational immediate extender.
//   mode  : extension mode (SIGN / ZERO / LUI / BRANCH)
//   imm   : IN_W-bit immediate
//   data  : OUT_W-bit extended result
//   trunc : BRANCH result dropped significant bits (0 in other modes)
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 30,
  parameter int SHIFT = 2
) (
  input  logic [EXT_MODE_W-1:0] mode,
  input  logic [IN_W-1:0]       imm,
  output logic [OUT_W-1:0]      data,
  output logic                  trunc
);

  if (IN_W < 2 || OUT_W < IN_W || SHIFT < 0 || SHIFT >= OUT_W) begin : g_bad_params
    $error("imm_ext_core: illegal IN_W/OUT_W/SHIFT");
  end

  // shifted value is kept SHIFT bits wider so overflow can be detected
  localparam int TW = OUT_W + SHIFT;

  logic [OUT_W-1:0] sx, zx, lui;
  logic [TW-1:0]    t;
  logic             br_trunc;

  // built bit by bit so IN_W == OUT_W needs no zero-width replication
  for (genvar i = 0; i < OUT_W; i++) begin : g_ext
    if (i < IN_W) begin : g_lo
      assign sx[i] = imm[i];
      assign zx[i] = imm[i];
    end else begin : g_hi
      assign sx[i] = imm[IN_W-1];
      assign zx[i] = 1'b0;
    end
    if (i >= OUT_W - IN_W) begin : g_lui_hi
      assign lui[i] = imm[i-(OUT_W-IN_W)];
    end else begin : g_lui_lo
      assign lui[i] = 1'b0;
    end
  end

  for (genvar j = 0; j < TW; j++) begin : g_t
    if (j < SHIFT) begin : g_z
      assign t[j] = 1'b0;
    end else if (j - SHIFT < IN_W) begin : g_v
      assign t[j] = imm[j-SHIFT];
    end else begin : g_s
      assign t[j] = imm[IN_W-1];
    end
  end

  // the result is only faithful if every bit from the new sign position
  // upward agrees; otherwise the shift pushed magnitude off the top
  assign br_trunc = ~(&t[TW-1:OUT_W-1] | ~|t[TW-1:OUT_W-1]);

  always_comb begin
    data  = '0;
    trunc = 1'b0;
    case (ext_mode_e'(mode))
      EXT_SIGN: data = sx;
      EXT_ZERO: data = zx;
      EXT_LUI:  data = lui;
      EXT_BRANCH: begin
        data  = t[OUT_W-1:0];
        trunc = br_trunc;
      end
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Two-stage valid/ready immediate-extension pipeline.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : imm_ext_pipe_if slave (request in, result out, busy)
// Stage 1 registers the raw immediate and mode; stage 2 registers the
// extended result and trunc flag. Ready propagates backwards
// combinationally, so a full pipeline with a stalled consumer refuses
// input in the same cycle and there is no skid storage.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 30,
  parameter int SHIFT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  imm_ext_pipe_if.slave bus
);

  if (IN_W < 2 || OUT_W < IN_W || SHIFT < 0 || SHIFT >= OUT_W) begin : g_bad_params
    $error("imm_ext_pipe: illegal IN_W/OUT_W/SHIFT");
  end
  if ($bits(bus.in_imm) != IN_W || $bits(bus.out_data) != OUT_W) begin : g_bad_if
    $error("imm_ext_pipe: interface widths do not match parameters");
  end

  localparam int STAGES = PIPE_STAGES;

  // vld_pipe[1] = stage 1 valid, vld_pipe[2] = stage 2 valid
  logic [STAGES:1]       vld_pipe;
  logic [IN_W-1:0]       s1_imm;
  logic [EXT_MODE_W-1:0] s1_mode;
  logic [OUT_W-1:0]      s2_data;
  logic                  s2_trunc;
  logic [OUT_W-1:0]      core_data;
  logic                  core_trunc;
  logic                  s1_load, s2_load, out_fire;

  assign out_fire = vld_pipe[2] & bus.out_ready;
  // stage 2 frees up either by being empty or by handing off this edge
  assign s2_load  = vld_pipe[1] & (~vld_pipe[2] | bus.out_ready);
  // gated with rst_n so nothing is accepted while reset is held
  assign bus.in_ready = rst_n & (~vld_pipe[1] | ~vld_pipe[2] | bus.out_ready);
  assign s1_load  = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      if (s1_load)       vld_pipe[1] <= 1'b1;
      else if (s2_load)  vld_pipe[1] <= 1'b0;
      if (s2_load)       vld_pipe[2] <= 1'b1;
      else if (out_fire) vld_pipe[2] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_imm  <= '0;
      s1_mode <= '0;
    end else if (s1_load) begin
      s1_imm  <= bus.in_imm;
      s1_mode <= bus.in_mode;
    end
  end

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_core (
    .mode  (s1_mode),
    .imm   (s1_imm),
    .data  (core_data),
    .trunc (core_trunc)
  );

  // held while the consumer stalls: s2_load is low whenever s2 is
  // occupied and out_ready is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_data  <= '0;
      s2_trunc <= 1'b0;
    end else if (s2_load) begin
      s2_data  <= core_data;
      s2_trunc <= core_trunc;
    end
  end

  assign bus.out_valid = vld_pipe[2];
  assign bus.out_data  = s2_data;
  assign bus.out_trunc = s2_trunc;
  assign bus.busy      = |vld_pipe;

endmodule

// File: tb/tb_imm_ext_pipe.sv
module tb_imm_ext_pipe;
  import imm_ext_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imm_ext_pipe_if #(.IN_W(16), .OUT_W(30)) bus ();
  imm_ext_pipe_if #(.IN_W(16), .OUT_W(16)) nb ();

  imm_ext_pipe #(.IN_W(16), .OUT_W(30), .SHIFT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  imm_ext_pipe #(.IN_W(16), .OUT_W(16), .SHIFT(2)) u_narrow (
    .clk(clk), .rst_n(rst_n), .bus(nb)
  );

  int checks = 0;
  int failures = 0;
  int out_cnt = 0;

  typedef struct {
    logic [29:0] d;
    bit          t;
  } exp_t;
  exp_t exp_q[$];

  // Reference: treat the immediate as an integer and apply the mode rule
  // arithmetically; trunc means the shifted value does not fit ow signed bits.
  function automatic void model(input int ow, input logic [1:0] m,
                                input logic [15:0] x,
                                output logic [29:0] d, output bit tr);
    longint v, t, half, mask, r;
    v    = x[15] ? longint'(x) - 65536 : longint'(x);
    half = longint'(1) << (ow - 1);
    mask = (longint'(1) << ow) - 1;
    tr   = 0;
    r    = 0;
    t    = 0;
    case (m)
      2'b00: r = v & mask;
      2'b01: r = longint'(x);
      2'b10: r = longint'(x) * (longint'(1) << (ow - 16));
      default: begin
        t  = v * 4;
        r  = t & mask;
        tr = (t < -half) || (t >= half);
      end
    endcase
    d = r[29:0];
  endfunction

  // Scoreboard on the wide instance: every output transfer must match the
  // oldest accepted input; reset discards everything in flight.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        out_cnt++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_unexpected got=%h trunc=%b expected no output", bus.out_data, bus.out_trunc);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e.d || bus.out_trunc !== e.t) begin
            failures++;
            $display("FAIL scoreboard_order got=%h/%b expected=%h/%b", bus.out_data, bus.out_trunc, e.d, e.t);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        model(30, bus.in_mode, bus.in_imm, e.d, e.t);
        exp_q.push_back(e);
      end
    end
  end

  task automatic send(input logic [1:0] m, input logic [15:0] x);
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_imm   = x;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    for (int k = 0; k < 20 && bus.busy; k++) begin
      @(posedge clk); #1;
    end
    ok = !bus.busy;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 30'd0 ||
        bus.out_trunc !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state rdy=%b vld=%b data=%h trunc=%b busy=%b expected 0/0/0/0/0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_trunc, bus.busy);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release in_ready=%b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_modes;
    logic [1:0]  tm[7] = '{EXT_SIGN, EXT_SIGN, EXT_ZERO, EXT_LUI, EXT_BRANCH, EXT_BRANCH, EXT_BRANCH};
    logic [15:0] ti[7] = '{16'd23, 16'hFFE9, 16'hFFE9, 16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000};
    logic [29:0] td[7] = '{30'd23, 30'h3FFFFFE9, 30'h0000FFE9, 30'h048D0000,
                           30'h3FFFFFFC, 30'h0001FFFC, 30'h3FFE0000};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(tm[i], ti[i]);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL mode_latency_early idx=%0d out_valid=%b expected 0", i, bus.out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== td[i] || bus.out_trunc !== 1'b0) begin
        failures++;
        $display("FAIL mode_result idx=%0d vld=%b data=%h trunc=%b expected 1/%h/0",
                 i, bus.out_valid, bus.out_data, bus.out_trunc, td[i]);
      end
    end
  endtask

  task automatic test_narrow;
    logic [29:0] d;
    bit          tr;
    logic [15:0] x;
    logic [1:0]  m;
    nb.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        m = EXT_BRANCH; x = 16'h2000;
      end else begin
        m = 2'($urandom_range(0, 3)); x = 16'($urandom);
      end
      nb.in_valid = 1'b1; nb.in_mode = m; nb.in_imm = x;
      @(posedge clk); #1;
      nb.in_valid = 1'b0;
      @(posedge clk); #1;
      model(16, m, x, d, tr);
      if (i == 0) begin
        checks++;
        if (nb.out_data !== 16'h8000 || nb.out_trunc !== 1'b1) begin
          failures++;
          $display("FAIL narrow_branch data=%h trunc=%b expected 8000/1", nb.out_data, nb.out_trunc);
        end
      end
      checks++;
      if (nb.out_valid !== 1'b1 || nb.out_data !== d[15:0] || nb.out_trunc !== tr) begin
        failures++;
        $display("FAIL narrow_model mode=%0d imm=%h vld=%b data=%h trunc=%b expected 1/%h/%b",
                 m, x, nb.out_valid, nb.out_data, nb.out_trunc, d[15:0], tr);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [1:0]  em[4] = '{EXT_SIGN, EXT_ZERO, EXT_LUI, EXT_BRANCH};
    logic [15:0] ei[4] = '{16'h8001, 16'h1234, 16'hABCD, 16'h4001};
    logic [29:0] d0;
    bit          t0, ok, acc;
    int          oc;
    oc = out_cnt;
    model(30, em[0], ei[0], d0, t0);
    bus.out_ready = 1'b1;
    send(em[0], ei[0]);
    send(em[1], ei[1]);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_mode = em[2]; bus.in_imm = ei[2];
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_full rdy=%b vld=%b busy=%b expected 0/1/1", bus.in_ready, bus.out_valid, bus.busy);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== d0 || bus.out_trunc !== t0 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d vld=%b data=%h rdy=%b expected 1/%h/0",
                 c, bus.out_valid, bus.out_data, bus.in_ready, d0);
      end
    end
    bus.out_ready = 1'b1;
    for (int i = 2; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_mode = em[i]; bus.in_imm = ei[i];
      acc = 0;
      for (int k = 0; k < 10 && !acc; k++) begin
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk); #1;
      end
      if (!acc) begin
        checks++; failures++;
        $display("FAIL bp_accept_timeout idx=%0d in_ready=0 expected 1", i);
      end
    end
    bus.in_valid = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok || out_cnt - oc !== 4 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL bp_count outputs=%0d pending=%0d idle=%0d expected 4/0/1", out_cnt - oc, exp_q.size(), ok);
    end
  endtask

  task automatic test_simul;
    logic [29:0] d1;
    bit          t1, ok;
    int          oc;
    model(30, EXT_BRANCH, 16'hC003, d1, t1);
    bus.out_ready = 1'b0;
    send(EXT_ZERO, 16'h0F0F);
    send(EXT_BRANCH, 16'hC003);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL simul_full rdy=%b busy=%b vld=%b expected 0/1/1", bus.in_ready, bus.busy, bus.out_valid);
    end
    oc = out_cnt;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_mode = EXT_LUI; bus.in_imm = 16'h00FF;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL simul_ready in_ready=%b expected 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_data !== d1 ||
        bus.out_trunc !== t1 || out_cnt - oc !== 1) begin
      failures++;
      $display("FAIL simul_advance busy=%b vld=%b data=%h outs=%0d expected 1/1/%h/1",
               bus.busy, bus.out_valid, bus.out_data, out_cnt - oc, d1);
    end
    wait_idle(ok);
    checks++;
    if (!ok || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL simul_drain idle=%0d pending=%0d expected 1/0", ok, exp_q.size());
    end
  endtask

  task automatic test_random;
    bit          stall, ok;
    logic [29:0] pd;
    bit          pt;
    stall = 0; pd = '0; pt = 0;
    for (int c = 0; c < 300; c++) begin
      if (stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== pd || bus.out_trunc !== pt) begin
          failures++;
          $display("FAIL rand_stall cyc=%0d vld=%b data=%h expected 1/%h", c, bus.out_valid, bus.out_data, pd);
        end
      end
      checks++;
      if (bus.busy !== (exp_q.size() != 0)) begin
        failures++;
        $display("FAIL rand_busy cyc=%0d busy=%b expected %0d", c, bus.busy, exp_q.size() != 0);
      end
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_mode   = 2'($urandom_range(0, 3));
      bus.in_imm    = 16'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      #1;
      checks++;
      if (bus.in_ready !== !(exp_q.size() == 2 && !bus.out_ready)) begin
        failures++;
        $display("FAIL rand_in_ready cyc=%0d in_ready=%b expected %0d", c, bus.in_ready,
                 !(exp_q.size() == 2 && !bus.out_ready));
      end
      stall = bus.out_valid && !bus.out_ready;
      pd = bus.out_data;
      pt = bus.out_trunc;
      @(posedge clk); #1;
    end
    wait_idle(ok);
    checks++;
    if (!ok || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL rand_drain idle=%0d pending=%0d expected 1/0", ok, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight;
    logic [29:0] dn;
    bit          tn, ok;
    model(30, EXT_SIGN, 16'hF00D, dn, tn);
    bus.out_ready = 1'b0;
    send(EXT_LUI, 16'hBEEF);
    send(EXT_ZERO, 16'hCAFE);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 30'd0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_clear vld=%b data=%h rdy=%b busy=%b expected 0/0/0/0",
               bus.out_valid, bus.out_data, bus.in_ready, bus.busy);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_release in_ready=%b expected 1", bus.in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL midreset_stale cyc=%0d vld=%b busy=%b expected 0/0", c, bus.out_valid, bus.busy);
      end
    end
    send(EXT_SIGN, 16'hF00D);
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== dn) begin
      failures++;
      $display("FAIL midreset_new vld=%b data=%h expected 1/%h", bus.out_valid, bus.out_data, dn);
    end
    wait_idle(ok);
    checks++;
    if (!ok || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL midreset_drain idle=%0d pending=%0d expected 1/0", ok, exp_q.size());
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_imm = '0; bus.in_mode = '0; bus.out_ready = 1'b1;
    nb.in_valid  = 1'b0; nb.in_imm  = '0; nb.in_mode  = '0; nb.out_ready  = 1'b1;
    test_reset;
    test_modes;
    test_narrow;
    test_backpressure;
    test_simul;
    test_random;
    test_reset_midflight;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
